dnn_result_collector: RTL and testbench
=======================================

// Module: dnn_result_collector
// PURPOSE
// - Downstream consumer of the DNN output layer. Pairs the two output-neuron results (out0/out1), which may arrive
//   in different cycles, and classifies each pair (argmax + margin).
// - Buffers the classified results in a FIFO and presents them to the host over a valid/ready handshake.
// PARAMETERS
// - OUT_W        17   width of each signed DNN output (matches output layer width)
// - FIFO_DEPTH   4    result FIFO entries; power of 2, >= 2
// - TIMEOUT_CYC  64   max cycles in HALF before abandoning a pair (used only with macro)
// PORTS
// - clk         in   1             clock; all state on rising edge
// - rst_n       in   1             asynchronous active-low reset
// - in0_ready   in   1             1-cycle strobe: in0 valid (from out0_ready)
// - in1_ready   in   1             1-cycle strobe: in1 valid (from out1_ready)
// - in0, in1    in   OUT_W s       DNN outputs
// - clr_err     in   1             synchronous clear of sticky error flags
// - res_ready   in   1             host accepts head entry
// - res_valid   out  1             FIFO non-empty
// - res_class   out  1             0: in0 won (incl. tie), 1: in1 won
// - res_max     out  OUT_W s       winning value
// - res_margin  out  OUT_W+1 u     |in0 - in1|
// - fifo_cnt    out  log2(D)+1     occupancy
// - err_ovf     out  1             sticky: pair dropped on full FIFO
// - err_dup     out  1             sticky: strobe for an already-held half
// - err_tmo     out  1             sticky: pair abandoned on timeout (0 without macro)
// BEHAVIOUR
// - Reset: FSM=IDLE, held halves cleared, FIFO empty; all outputs 0.
// - FSM IDLE: both strobes -> PAIR; one strobe -> HALF (latch that half); none -> IDLE.
// - FSM HALF: missing strobe -> PAIR.
//   - Strobe for the held half -> overwrite the value, set err_dup, stay in HALF.
//   - Both strobes -> overwrite the held half, take the other, set err_dup, -> PAIR.
// - FSM PAIR (1 cycle): compute and push. Strobes in this cycle start the next pair (-> HALF or PAIR).
//   - They never corrupt the pair being pushed (pair held in dedicated regs).
// - Arithmetic: diff = in0 - in1, sign-extended to OUT_W+1 (no overflow).
//   - res_class = (in1 > in0); res_max = class ? in1 : in0; res_margin = |diff|, exact in OUT_W+1 bits.
// - Latency: strobes complete the pair in cycle N -> PAIR in N+1 -> FIFO write at end of N+1 -> res_valid high in N+2.
// - Sustained throughput: 1 pair/cycle.
// - FIFO: res_* show the head entry, stable while res_valid && !res_ready. Pop when res_valid && res_ready.
//   - Full: a push with no pop in the same cycle -> pair dropped, err_ovf set, contents unchanged.
//   - Push and pop in the same cycle when full -> both succeed, count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Empty: res_valid=0; res_* hold the last popped value, or 0 after reset.
// - clr_err clears all sticky flags; an error event in the same cycle wins (flag stays 1).
// - Async reset mid-pair discards held halves and FIFO contents immediately.
// CONFIGURATION
// - `DNN_RESULT_TIMEOUT_EN defined:
//   - Counter runs in HALF and clears on entry to HALF.
//   - Reaching TIMEOUT_CYC with the half unmatched -> discard the half, set err_tmo, -> IDLE.
//   - A matching strobe in the expiry cycle wins (-> PAIR, no error).
// - Not defined: no counter; HALF waits indefinitely; err_tmo tied 0.
// TESTING
// - in0=100,in1=-20 same cycle, res_ready=1 -> 2 cycles later res_valid=1, class=0, max=100, margin=120.
// - in1=5 strobed, in0=5 three cycles later -> class=0 (tie), margin=0; no errors.
// - in0=-65536,in1=65535 -> class=1, max=65535, margin=131071 (no wrap).
// - res_ready=0, push FIFO_DEPTH+1 pairs -> fifo_cnt=4, err_ovf=1, first 4 entries intact in order.
//   - Then pop+push same cycle at full -> cnt stays 4.
// - in0 strobed twice (7 then 9), then in1=3 -> err_dup=1, pair uses 9; clr_err -> err_dup=0.
// - With `DNN_RESULT_TIMEOUT_EN: in0 only, wait 64 cycles -> err_tmo=1, IDLE, nothing pushed.
//   - Assert rst_n low mid-HALF -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dnn_result_collector.sv
// Pairs the two DNN output-neuron results, classifies each pair (argmax + margin) and
// queues the results for the host. Optional half-pair timeout: define DNN_RESULT_TIMEOUT_EN.
module dnn_result_collector #(
    parameter int OUT_W       = 17,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in0_ready,
    input  logic                          in1_ready,
    input  logic signed [OUT_W-1:0]       in0,
    input  logic signed [OUT_W-1:0]       in1,
    input  logic                          clr_err,
    input  logic                          res_ready,
    output logic                          res_valid,
    output logic                          res_class,
    output logic signed [OUT_W-1:0]       res_max,
    output logic [OUT_W:0]                res_margin,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          err_ovf,
    output logic                          err_dup,
    output logic                          err_tmo
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * OUT_W + 2;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HALF = 2'd1;
    localparam logic [1:0] S_PAIR = 2'd2;

    logic [1:0]              state;
    logic                    held_sel;
    logic signed [OUT_W-1:0] held_val;
    logic signed [OUT_W-1:0] pair0;
    logic signed [OUT_W-1:0] pair1;
    logic                    hit_match;
    logic                    hit_dup;
    logic                    tmo_fire;

    logic signed [OUT_W:0]   diff;
    logic                    cls;
    logic signed [OUT_W-1:0] winner;
    logic [OUT_W:0]          margin;
    logic [EW-1:0]           entry;

    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [EW-1:0]           last_q;
    logic [EW-1:0]           shown;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             cnt;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    push_ok;

    // held_sel: 0 = in0 is the held half, 1 = in1 is the held half
    always_comb begin
        hit_match = 1'b0;
        hit_dup   = 1'b0;
        if (state == S_HALF) begin
            hit_match = held_sel ? in0_ready : in1_ready;
            hit_dup   = held_sel ? in1_ready : in0_ready;
        end
    end

`ifdef DNN_RESULT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_fire = (state == S_HALF) && !hit_match && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != S_HALF) begin
            tmo_cnt <= '0;
        end else if (!tmo_fire) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tmo <= 1'b0;
        end else if (tmo_fire) begin
            err_tmo <= 1'b1;
        end else if (clr_err) begin
            err_tmo <= 1'b0;
        end
    end
`else
    assign tmo_fire = 1'b0;
    // constant 0 for any legal TIMEOUT_CYC; the counter only exists in the timeout build
    assign err_tmo  = (TIMEOUT_CYC < 0);
`endif

    // The pair is copied into pair0/pair1 on completion, so strobes arriving while
    // in PAIR can start the next pair without disturbing the one being pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            held_sel <= 1'b0;
            held_val <= '0;
            pair0    <= '0;
            pair1    <= '0;
        end else begin
            case (state)
                S_HALF: begin
                    if (hit_match) begin
                        state <= S_PAIR;
                        pair0 <= (!held_sel && !in0_ready) ? held_val : in0;
                        pair1 <= ( held_sel && !in1_ready) ? held_val : in1;
                    end else if (tmo_fire) begin
                        state    <= S_IDLE;
                        held_val <= '0;
                    end else if (hit_dup) begin
                        held_val <= held_sel ? in1 : in0;
                    end
                end
                default: begin
                    if (in0_ready && in1_ready) begin
                        state <= S_PAIR;
                        pair0 <= in0;
                        pair1 <= in1;
                    end else if (in0_ready) begin
                        state    <= S_HALF;
                        held_sel <= 1'b0;
                        held_val <= in0;
                    end else if (in1_ready) begin
                        state    <= S_HALF;
                        held_sel <= 1'b1;
                        held_val <= in1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // One extra bit keeps the difference exact; its sign is the class bit.
    always_comb begin
        diff   = {pair0[OUT_W-1], pair0} - {pair1[OUT_W-1], pair1};
        cls    = diff[OUT_W];
        winner = cls ? pair1 : pair0;
        margin = cls ? $unsigned(-diff) : $unsigned(diff);
        entry  = {cls, winner, margin};
    end

    assign push    = (state == S_PAIR);
    assign pop     = (cnt != '0) && res_ready;
    assign full    = (cnt == DEPTH_C);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_dup <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                err_ovf <= 1'b1;
            end else if (clr_err) begin
                err_ovf <= 1'b0;
            end
            if (hit_dup) begin
                err_dup <= 1'b1;
            end else if (clr_err) begin
                err_dup <= 1'b0;
            end
        end
    end

    // When empty, the outputs keep showing the most recently popped entry.
    assign shown     = (cnt != '0) ? mem[rd_ptr] : last_q;
    assign res_valid = (cnt != '0);
    assign fifo_cnt  = cnt;
    assign {res_class, res_max, res_margin} = shown;

endmodule

// File: tb/tb_dnn_result_collector.sv
// Self-checking bench for dnn_result_collector: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_dnn_result_collector;

    localparam int OUT_W = 17;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    in0_ready = 1'b0;
    logic                    in1_ready = 1'b0;
    logic signed [OUT_W-1:0] in0       = '0;
    logic signed [OUT_W-1:0] in1       = '0;
    logic                    clr_err   = 1'b0;
    logic                    res_ready = 1'b0;
    logic                    res_valid;
    logic                    res_class;
    logic signed [OUT_W-1:0] res_max;
    logic [OUT_W:0]          res_margin;
    logic [2:0]              fifo_cnt;
    logic                    err_ovf;
    logic                    err_dup;
    logic                    err_tmo;

    int checks   = 0;
    int failures = 0;

    typedef struct { int a; int b; bit cls; int mx; int mg; } vec_t;
    typedef struct { bit cls; int mx; int mg; } res_t;

    dnn_result_collector #(
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_ready (in0_ready),
        .in1_ready (in1_ready),
        .in0       (in0),
        .in1       (in1),
        .clr_err   (clr_err),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_class (res_class),
        .res_max   (res_max),
        .res_margin(res_margin),
        .fifo_cnt  (fifo_cnt),
        .err_ovf   (err_ovf),
        .err_dup   (err_dup),
        .err_tmo   (err_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // strobes are held for exactly one clock, then dropped
    task automatic drive(input bit s0, input int v0, input bit s1, input int v1);
        in0_ready = s0;
        in1_ready = s1;
        if (s0) in0 = OUT_W'(v0);
        if (s1) in1 = OUT_W'(v1);
        cyc(1);
        in0_ready = 1'b0;
        in1_ready = 1'b0;
    endtask

    task automatic chk_res(input string name, input bit c, input int mx, input int mg);
        chk({name, "_valid"},  res_valid,  1);
        chk({name, "_class"},  res_class,  c);
        chk({name, "_max"},    res_max,    mx);
        chk({name, "_margin"}, res_margin, mg);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"},  res_valid,  0);
        chk({name, "_class"},  res_class,  0);
        chk({name, "_max"},    res_max,    0);
        chk({name, "_margin"}, res_margin, 0);
        chk({name, "_cnt"},    fifo_cnt,   0);
        chk({name, "_ovf"},    err_ovf,    0);
        chk({name, "_dup"},    err_dup,    0);
        chk({name, "_tmo"},    err_tmo,    0);
    endtask

    function automatic res_t classify(input int a, input int b);
        res_t r;
        r.cls = (b > a);
        r.mx  = r.cls ? b : a;
        r.mg  = (a > b) ? (a - b) : (b - a);
        return r;
    endfunction

    // reference model state
    res_t q[$];
    res_t last;
    bit   h0v, h1v, pv;
    int   h0, h1, pa, pb;
    bit   m_ovf, m_dup;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[7];
        int   exp_q[4];
        res_t e;
        bit   s0, s1, rdy, clr;
        int   v0, v1;
        int   mode;

        tbl[0] = '{a: 100,    b: -20,    cls: 1'b0, mx: 100,    mg: 120};
        tbl[1] = '{a: -65536, b: 65535,  cls: 1'b1, mx: 65535,  mg: 131071};
        tbl[2] = '{a: 65535,  b: -65536, cls: 1'b0, mx: 65535,  mg: 131071};
        tbl[3] = '{a: 5,      b: 5,      cls: 1'b0, mx: 5,      mg: 0};
        tbl[4] = '{a: -3,     b: -1,     cls: 1'b1, mx: -1,     mg: 2};
        tbl[5] = '{a: 0,      b: 1,      cls: 1'b1, mx: 1,      mg: 1};
        tbl[6] = '{a: -65536, b: -65536, cls: 1'b0, mx: -65536, mg: 0};

        // reset state
        cyc(1);
        chk_zero("reset");
        rst_n = 1'b1;
        cyc(1);

        // classification vectors, both strobes in one cycle
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].a, 1'b1, tbl[i].b);
            chk("tbl_pair_cycle_valid", res_valid, 0);
            cyc(1);
            chk_res($sformatf("tbl%0d", i), tbl[i].cls, tbl[i].mx, tbl[i].mg);
            cyc(1);
            chk("tbl_popped_valid", res_valid, 0);
            chk("tbl_hold_max", res_max, tbl[i].mx);
            chk("tbl_hold_margin", res_margin, tbl[i].mg);
        end

        // halves three cycles apart, tie
        drive(1'b0, 0, 1'b1, 5);
        cyc(2);
        drive(1'b1, 5, 1'b0, 0);
        chk("split_pair_cycle_valid", res_valid, 0);
        cyc(1);
        chk_res("split_tie", 1'b0, 5, 0);
        chk("split_dup", err_dup, 0);
        chk("split_ovf", err_ovf, 0);
        cyc(1);

        // duplicate half: 7 overwritten by 9
        drive(1'b1, 7, 1'b0, 0);
        drive(1'b1, 9, 1'b0, 0);
        drive(1'b0, 0, 1'b1, 3);
        chk("dup_flag", err_dup, 1);
        cyc(1);
        chk_res("dup_pair", 1'b0, 9, 6);
        cyc(1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("dup_cleared", err_dup, 0);

        // duplicate in the same cycle as clr_err: the event wins
        drive(1'b1, 1, 1'b0, 0);
        clr_err = 1'b1;
        drive(1'b1, 2, 1'b0, 0);
        clr_err = 1'b0;
        chk("dup_vs_clr", err_dup, 1);
        drive(1'b0, 0, 1'b1, 0);
        cyc(1);
        chk_res("dup2_pair", 1'b0, 2, 2);
        cyc(1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("dup2_cleared", err_dup, 0);

        // overflow: five back-to-back pairs into a 4-deep FIFO with no pops
        res_ready = 1'b0;
        for (int k = 1; k <= 5; k++) drive(1'b1, 10 * k, 1'b1, 0);
        chk("ovf_cnt_at_full", fifo_cnt, 4);
        chk("ovf_not_yet", err_ovf, 0);
        cyc(1);
        chk("ovf_cnt", fifo_cnt, 4);
        chk("ovf_flag", err_ovf, 1);
        chk_res("ovf_head", 1'b0, 10, 10);
        // push and pop in the same cycle while full
        drive(1'b1, 60, 1'b1, 0);
        res_ready = 1'b1;
        cyc(1);
        res_ready = 1'b0;
        chk("pushpop_cnt", fifo_cnt, 4);
        chk("pushpop_head", res_max, 20);
        exp_q = '{20, 30, 40, 60};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_res($sformatf("drain%0d", i), 1'b0, exp_q[i], exp_q[i]);
            cyc(1);
        end
        chk("drain_empty_valid", res_valid, 0);
        chk("drain_empty_cnt", fifo_cnt, 0);
        chk("drain_hold_max", res_max, 60);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("ovf_cleared", err_ovf, 0);

`ifdef DNN_RESULT_TIMEOUT_EN
        drive(1'b1, 11, 1'b0, 0);
        cyc(TMO - 1);
        chk("tmo_not_yet", err_tmo, 0);
        cyc(1);
        chk("tmo_flag", err_tmo, 1);
        chk("tmo_cnt", fifo_cnt, 0);
        drive(1'b0, 0, 1'b1, 12);
        cyc(2);
        chk("tmo_half_discarded", res_valid, 0);
        chk("tmo_nothing_pushed", fifo_cnt, 0);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("tmo_cleared", err_tmo, 0);
`else
        drive(1'b1, 11, 1'b0, 0);
        cyc(100);
        chk("notmo_flag", err_tmo, 0);
        drive(1'b0, 0, 1'b1, 12);
        cyc(1);
        chk_res("notmo_pair", 1'b1, 12, 1);
        cyc(1);
`endif

        // asynchronous reset while a half is held and the FIFO has data
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        res_ready = 1'b0;
        drive(1'b1, -5, 1'b1, -7);
        drive(1'b1, 8, 1'b1, 8);
        cyc(1);
        drive(1'b1, 4, 1'b0, 0);
        drive(1'b1, 6, 1'b0, 0);
        chk("arst_pre_cnt", fifo_cnt, 2);
        chk("arst_pre_dup", err_dup, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        cyc(1);
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b1, 3);
        cyc(2);
        chk("arst_half_gone", res_valid, 0);

        // randomized run against the reference model
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        q.delete();
        last  = '{cls: 1'b0, mx: 0, mg: 0};
        h0v   = 1'b0;
        h1v   = 1'b0;
        pv    = 1'b0;
        m_ovf = 1'b0;
        m_dup = 1'b0;
        mode  = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) @(negedge clk);
            e = (q.size() > 0) ? q[0] : last;
            chk("rnd_valid", res_valid, (q.size() > 0) ? 1 : 0);
            chk("rnd_cnt", fifo_cnt, q.size());
            chk("rnd_class", res_class, e.cls);
            chk("rnd_max", res_max, e.mx);
            chk("rnd_margin", res_margin, e.mg);
            chk("rnd_ovf", err_ovf, m_ovf);
            chk("rnd_dup", err_dup, m_dup);
            chk("rnd_tmo", err_tmo, 0);

            if (n % 50 == 0) mode = int'($urandom_range(0, 1));
            s0  = ($urandom_range(0, 9) < 6);
            s1  = ($urandom_range(0, 9) < 6);
            rdy = mode ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            clr = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 7))
                0:       v0 = -65536;
                1:       v0 = 65535;
                default: v0 = int'($urandom_range(0, 131071)) - 65536;
            endcase
            case ($urandom_range(0, 7))
                0:       v1 = -65536;
                1:       v1 = 65535;
                default: v1 = int'($urandom_range(0, 131071)) - 65536;
            endcase
            in0_ready = s0;
            in1_ready = s1;
            in0       = OUT_W'(v0);
            in1       = OUT_W'(v1);
            res_ready = rdy;
            clr_err   = clr;

            @(posedge clk);
            begin
                bit ev_ovf;
                bit ev_dup;
                ev_ovf = 1'b0;
                ev_dup = 1'b0;
                if (rdy && q.size() > 0) last = q.pop_front();
                if (pv) begin
                    if (q.size() < DEPTH) q.push_back(classify(pa, pb));
                    else ev_ovf = 1'b1;
                end
                pv = 1'b0;
                if (s0) begin
                    if (h0v) ev_dup = 1'b1;
                    h0v = 1'b1;
                    h0  = v0;
                end
                if (s1) begin
                    if (h1v) ev_dup = 1'b1;
                    h1v = 1'b1;
                    h1  = v1;
                end
                if (h0v && h1v) begin
                    pv  = 1'b1;
                    pa  = h0;
                    pb  = h1;
                    h0v = 1'b0;
                    h1v = 1'b0;
                end
                m_ovf = ev_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
                m_dup = ev_dup ? 1'b1 : (clr ? 1'b0 : m_dup);
            end
        end
        @(negedge clk);
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        clr_err   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
